game_sequencer: RTL

//   Top-level game-flow controller for Doodle Jump. Sequences jumplogic (run enable,

---
 rtl/game_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/game_sequencer.sv
// Game-flow controller for Doodle Jump: frame tick sync, key-press decode,
// IDLE/PLAY/PAUSE/DYING/OVER sequencing and BCD score / high-score keeping.
module game_sequencer #(
  parameter int unsigned SCREEN_H     = 480,
  parameter logic [7:0]  START_KEY    = 8'h2C,
  parameter logic [7:0]  PAUSE_KEY    = 8'h13,
  parameter int unsigned DEATH_FRAMES = 120
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallS,
  input  logic        climb,
  output logic [2:0]  outstate,
  output logic        game_run,
  output logic        game_reset,
  output logic        frame_tick,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_DYING = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam int unsigned CW = $clog2(DEATH_FRAMES + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(DEATH_FRAMES - 1);
  localparam logic [10:0]   BOTTOM    = 11'(SCREEN_H);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   score_q, score_d;
  logic [15:0]   hi_q, hi_d;
  logic          reset_d;
  logic          run_q, reset_q, tick_q;
  logic          fs1_q, fs2_q, fh_q;
  logic [7:0]    prev_key_q;

  logic          press_start, press_pause, dead;
  logic [10:0]   ball_bottom;

  // Decimal increment with ripple carry per digit; holds at 9999.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign press_start = (keycode == START_KEY) && (prev_key_q != START_KEY);
  assign press_pause = (keycode == PAUSE_KEY) && (prev_key_q != PAUSE_KEY);
  assign ball_bottom = {1'b0, BallY} + {1'b0, BallS};
  assign dead        = tick_q && (ball_bottom >= BOTTOM);

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    hi_d    = hi_q;
    reset_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_OVER: begin
        if (press_start) begin
          state_d = S_PLAY;
          reset_d = 1'b1;
          score_d = 16'h0000;
        end
      end
      S_PLAY: begin
        if (climb) score_d = bcd_inc(score_q);
        if (dead) begin
          state_d = S_DYING;
          cnt_d   = '0;
        end else if (press_pause) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (press_pause) state_d = S_PLAY;
      end
      S_DYING: begin
        if (tick_q) begin
          if (cnt_q == LAST_TICK) begin
            state_d = S_OVER;
            if (score_q > hi_q) hi_d = score_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      score_q    <= 16'h0000;
      hi_q       <= 16'h0000;
      run_q      <= 1'b0;
      reset_q    <= 1'b0;
      tick_q     <= 1'b0;
      fs1_q      <= 1'b0;
      fs2_q      <= 1'b0;
      fh_q       <= 1'b0;
      prev_key_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      run_q      <= (state_d == S_PLAY);
      reset_q    <= reset_d;
      // Two-flop synchroniser for VGA_VS, history flop for falling-edge detect.
      fs1_q      <= frame_clk;
      fs2_q      <= fs1_q;
      fh_q       <= fs2_q;
      tick_q     <= fh_q & ~fs2_q;
      prev_key_q <= keycode;
    end
  end

  assign outstate   = state_q;
  assign game_run   = run_q;
  assign game_reset = reset_q;
  assign frame_tick = tick_q;
  assign score_bcd  = score_q;
  assign hi_bcd     = hi_q;

endmodule
